// File: rtl/line_buffer_row_scheduler_if.sv
// Handshake bundle between the row scheduler, the upstream row source,
// the 3-row line buffer write port and the 3x3 conv engine.
interface line_buffer_row_scheduler_if #(
    parameter int ROW_W = 5
);
    logic             start_i;
    logic             row_valid_i;
    logic             row_ready_o;
    logic             lb_wr_o;
    logic             conv_start_o;
    logic [ROW_W-1:0] conv_row_o;
    logic             conv_done_i;
    logic             frame_done_o;
    logic             busy_o;
    logic             err_o;

    // Scheduler side
    modport master (
        input  start_i,
        input  row_valid_i,
        input  conv_done_i,
        output row_ready_o,
        output lb_wr_o,
        output conv_start_o,
        output conv_row_o,
        output frame_done_o,
        output busy_o,
        output err_o
    );

    // Environment side (upstream source, conv engine, frame control)
    modport slave (
        output start_i,
        output row_valid_i,
        output conv_done_i,
        input  row_ready_o,
        input  lb_wr_o,
        input  conv_start_o,
        input  conv_row_o,
        input  frame_done_o,
        input  busy_o,
        input  err_o
    );
endinterface

// File: rtl/line_buffer_row_scheduler.sv
// Row scheduler for the 3-row line buffer in front of the 3x3 conv stage.
// Fills three rows, then alternates "issue one conv command / fetch one new
// row" until H-2 output rows are done. Upstream is stalled while the conv
// engine reads the buffer, so resident rows are never overwritten.
module line_buffer_row_scheduler #(
    parameter int H     = 24,
    parameter int ROW_W = 5
) (
    input  logic                         clk,
    input  logic                         resetn,
    line_buffer_row_scheduler_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(H - 3);
    localparam logic [ROW_W-1:0] ROWS_FULL = ROW_W'(3);

    state_t           state;
    state_t           state_nxt;
    logic [ROW_W-1:0] rows_in;
    logic [ROW_W-1:0] rows_inc;
    logic [ROW_W-1:0] out_row;
    logic [ROW_W-1:0] conv_row;
    logic             err;
    logic             row_ready;
    logic             accept;

    assign rows_inc = rows_in + ROW_W'(1);
    assign accept   = bus.row_valid_i & row_ready;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived handshake outputs
    always_comb begin
        state_nxt = state;
        row_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                row_ready = 1'b1;
                if (bus.row_valid_i && (rows_inc >= ROWS_FULL)) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.conv_done_i) begin
                    state_nxt = (out_row == LAST_ROW) ? S_DONE : S_FILL;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Row counters and the registered command row index
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rows_in  <= '0;
            out_row  <= '0;
            conv_row <= '0;
        end else begin
            if (state == S_IDLE && bus.start_i) begin
                rows_in <= '0;
                out_row <= '0;
            end
            if (accept) begin
                rows_in <= rows_inc;
            end
            if (state == S_WAIT && bus.conv_done_i && out_row != LAST_ROW) begin
                out_row <= out_row + ROW_W'(1);
            end
            // Capture the row index as we enter ISSUE so it is valid with conv_start
            if (state == S_FILL && state_nxt == S_ISSUE) begin
                conv_row <= out_row;
            end
        end
    end

    // Sticky flag for a conv_done that arrives when no command is outstanding
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (bus.conv_done_i && state != S_WAIT) begin
            err <= 1'b1;
        end
    end

    assign bus.row_ready_o  = row_ready;
    assign bus.lb_wr_o      = accept;
    assign bus.conv_start_o = (state == S_ISSUE);
    assign bus.conv_row_o   = conv_row;
    assign bus.frame_done_o = (state == S_DONE);
    assign bus.busy_o       = (state != S_IDLE);
    assign bus.err_o        = err;

endmodule

// File: tb/tb_line_buffer_row_scheduler.sv
// Directed bench for line_buffer_row_scheduler: H=24 frames with varied
// upstream duty and conv latency, protocol-error cases, a minimum H=3
// frame, and asynchronous reset in the middle of filling.
module tb_line_buffer_row_scheduler;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    line_buffer_row_scheduler_if #(.ROW_W(5)) b24 ();
    line_buffer_row_scheduler_if #(.ROW_W(3)) b3 ();

    line_buffer_row_scheduler #(.H(24), .ROW_W(5)) dut24 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (b24)
    );

    line_buffer_row_scheduler #(.H(3), .ROW_W(3)) dut3 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame24();
        @(negedge clk);
        b24.start_i = 1'b1;
        @(negedge clk);
        b24.start_i = 1'b0;
    endtask

    // Run one H=24 frame. Inputs are driven at the falling edge, outputs
    // sampled 1 time unit later, well clear of the rising edge.
    task automatic run_frame24(input string name, input int delay, input int duty,
                               input bit inject_issue_done, input bit mid_start);
        int  cyc;
        int  accepts;
        int  issued;
        int  fdone;
        int  last_acc;
        int  wait_cnt;
        bit  in_wait;
        bit  fin;
        int  bad_wait;
        int  bad_row;
        int  bad_tag;
        int  bad_lat;
        cyc = 0; accepts = 0; issued = 0; fdone = 0; last_acc = -100;
        wait_cnt = 0; in_wait = 1'b0; fin = 1'b0;
        bad_wait = 0; bad_row = 0; bad_tag = 0; bad_lat = 0;
        start_frame24();
        // start_frame24 returned at a falling edge; loop begins at the next one
        while (!fin && cyc < 3000) begin
            b24.conv_done_i = 1'b0;
            b24.start_i     = (mid_start && cyc == 20);
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) b24.conv_done_i = 1'b1;
            end
            b24.row_valid_i = ($urandom_range(99) < duty);
            #1;
            if (cyc == 0) chk({name, "_busy"}, b24.busy_o, 1);
            if (b24.lb_wr_o) begin
                accepts++;
                last_acc = cyc;
            end
            if (in_wait && (b24.row_ready_o !== 1'b0 || b24.lb_wr_o !== 1'b0)) bad_wait++;
            if (b24.conv_done_i) in_wait = 1'b0;
            if (b24.conv_start_o) begin
                if (b24.conv_row_o !== 5'(issued)) bad_row++;
                if (accepts != issued + 3) bad_tag++;
                if (cyc != last_acc + 1) bad_lat++;
                issued++;
                in_wait  = 1'b1;
                wait_cnt = delay;
                if (inject_issue_done && issued == 1) b24.conv_done_i = 1'b1;
            end
            if (b24.frame_done_o) begin
                fdone++;
                fin = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        b24.conv_done_i = 1'b0;
        b24.row_valid_i = 1'b0;
        b24.start_i     = 1'b0;
        chk({name, "_timeout"}, fin, 1);
        chk({name, "_writes"}, accepts, 24);
        chk({name, "_cmds"}, issued, 22);
        chk({name, "_frame_done"}, fdone, 1);
        chk({name, "_stall_violations"}, bad_wait, 0);
        chk({name, "_row_order_errs"}, bad_row, 0);
        chk({name, "_row_tag_errs"}, bad_tag, 0);
        chk({name, "_issue_latency_errs"}, bad_lat, 0);
        #1;
        chk({name, "_idle_busy"}, b24.busy_o, 0);
        chk({name, "_idle_ready"}, b24.row_ready_o, 0);
        chk({name, "_idle_fdone"}, b24.frame_done_o, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        b24.start_i = 1'b0; b24.row_valid_i = 1'b0; b24.conv_done_i = 1'b0;
        b3.start_i  = 1'b0; b3.row_valid_i  = 1'b0; b3.conv_done_i  = 1'b0;

        // Reset state
        #12;
        chk("rst_ready", b24.row_ready_o, 0);
        chk("rst_busy", b24.busy_o, 0);
        chk("rst_err", b24.err_o, 0);
        chk("rst_start", b24.conv_start_o, 0);
        chk("rst_row", b24.conv_row_o, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Nominal: continuous rows, done 1 cycle after each command,
        // plus a start pulse mid-frame that must be ignored without error
        run_frame24("nominal", 1, 100, 1'b0, 1'b1);
        chk("nominal_err", b24.err_o, 0);

        // Backpressure: conv engine takes 10 cycles per command
        run_frame24("backpressure", 10, 100, 1'b0, 1'b0);
        chk("backpressure_err", b24.err_o, 0);

        // Bubbly upstream at roughly 30% duty
        run_frame24("bubbly", 2, 30, 1'b0, 1'b0);
        chk("bubbly_err", b24.err_o, 0);

        // conv_done in IDLE sets the sticky error
        @(negedge clk);
        b24.conv_done_i = 1'b1;
        @(negedge clk);
        b24.conv_done_i = 1'b0;
        #1;
        chk("err_idle_done", b24.err_o, 1);
        chk("err_idle_busy", b24.busy_o, 0);

        // conv_done during ISSUE: ignored for sequencing, error stays set
        run_frame24("errframe", 1, 100, 1'b1, 1'b0);
        chk("errframe_err", b24.err_o, 1);

        // Minimum frame on the H=3 instance
        @(negedge clk);
        b3.start_i = 1'b1;
        @(negedge clk);
        b3.start_i = 1'b0;
        b3.row_valid_i = 1'b1;
        #1;
        chk("h3_wr0", b3.lb_wr_o, 1);
        @(negedge clk);
        #1;
        chk("h3_wr1", b3.lb_wr_o, 1);
        @(negedge clk);
        #1;
        chk("h3_wr2", b3.lb_wr_o, 1);
        @(negedge clk);
        #1;
        chk("h3_issue", b3.conv_start_o, 1);
        chk("h3_row", b3.conv_row_o, 0);
        chk("h3_issue_ready", b3.row_ready_o, 0);
        chk("h3_issue_wr", b3.lb_wr_o, 0);
        @(negedge clk);
        b3.conv_done_i = 1'b1;
        #1;
        chk("h3_wait_start", b3.conv_start_o, 0);
        chk("h3_wait_wr", b3.lb_wr_o, 0);
        @(negedge clk);
        b3.conv_done_i = 1'b0;
        b3.row_valid_i = 1'b0;
        #1;
        chk("h3_frame_done", b3.frame_done_o, 1);
        chk("h3_done_busy", b3.busy_o, 1);
        @(negedge clk);
        #1;
        chk("h3_idle_busy", b3.busy_o, 0);
        chk("h3_idle_fdone", b3.frame_done_o, 0);
        chk("h3_err", b3.err_o, 0);

        // Asynchronous reset mid-FILL with two rows resident
        start_frame24();
        b24.row_valid_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midfill_ready", b24.row_ready_o, 1);
        resetn = 1'b0;
        #1;
        chk("arst_ready", b24.row_ready_o, 0);
        chk("arst_wr", b24.lb_wr_o, 0);
        chk("arst_busy", b24.busy_o, 0);
        chk("arst_err", b24.err_o, 0);
        chk("arst_start", b24.conv_start_o, 0);
        chk("arst_fdone", b24.frame_done_o, 0);
        b24.row_valid_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_ready", b24.row_ready_o, 0);
        chk("post_rst_busy", b24.busy_o, 0);

        // Fresh frame after reset starts from row 0
        run_frame24("post_rst", 1, 100, 1'b0, 1'b0);
        chk("post_rst_err", b24.err_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
